imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory that the pipeline's fetch stage reads. It accepts a framed byte stream from a serial receiver, assembles 16-bit big-endian words, and writes them into consecutive instruction-memory addresses. It holds the CPU in reset until a frame with a correct checksum has been loaded. It sits between the UART receive path and the instruction-memory write port, alongside the processor top.

## Interface
Parameters:
- ADDR_W, 16: instruction-memory address width; depth is 2^ADDR_W words.
- BASE_ADDR, 16'h0000: address of the first loaded word.
- TIMEOUT, 65535: maximum idle cycles allowed between bytes inside a frame.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous reset, active-high. The port name is kept for codebase compatibility; the level is high-true.
- rx_valid  in  1  a byte is present on rx_data.
- rx_data  in  8  received byte.
- rx_ready  out  1  loader can accept a byte. A byte transfers when rx_valid & rx_ready.
- im_we  out  1  instruction-memory write strobe, one cycle per word.
- im_addr  out  ADDR_W  write address.
- im_wdata  out  16  write data.
- cpu_hold  out  1  keeps the processor in reset while high.
- load_done  out  1  one-cycle pulse on a successful frame.
- load_err  out  1  sticky error flag; cleared when the next header is accepted.

## Operation
Frame format:
- 0xA5 header, CNT_HI, CNT_LO, then N words sent as 2 bytes each (high byte first), then CSUM.
- N = {CNT_HI, CNT_LO}.
- CSUM = XOR of CNT_HI, CNT_LO and all data bytes. The header byte is not included.

Byte acceptance:
- rx_ready = 1 in every state except WRITE.

FSM states: IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CSUM.
- IDLE: 0xA5 → CNT_HI; this clears load_err, the word index and the checksum register. Any other byte is accepted and discarded.
- CNT_HI → CNT_LO on a byte.
- CNT_LO on a byte:
  - If N == 0 or N > 2^ADDR_W: set load_err → IDLE.
  - Otherwise → DATA_HI.
- DATA_HI: latch the high byte → DATA_LO.
- DATA_LO: latch the low byte → WRITE.
- WRITE (exactly one cycle):
  - im_we = 1, im_addr = BASE_ADDR + idx (truncated to ADDR_W, wraps), im_wdata = {hi, lo}.
  - Then idx++.
  - If idx+1 == N → CSUM, else → DATA_HI.
- CSUM on a byte:
  - If it matches: load_done pulse, cpu_hold ← 0 → IDLE.
  - If it mismatches: load_err ← 1 → IDLE, and cpu_hold stays unchanged.
- cpu_hold rises to 1 when a header is accepted. It is released only by a good CSUM. An error after a header therefore leaves the CPU held.

Timeout:
- A counter clears on every accepted byte and runs in every state except IDLE and WRITE.
- When it reaches TIMEOUT: load_err ← 1 → IDLE, and the partial data already written stays in memory.

Internal registers:
- idx: 17 bits, so that N = 65536 works with ADDR_W = 16.
- csum: 8 bits.

## Timing
- Reset values: state IDLE, rx_ready 1, im_we 0, im_addr BASE_ADDR, im_wdata 0, cpu_hold 1, load_done 0, load_err 0, idx 0, csum 0, timer 0.
- A reset mid-frame aborts the frame immediately. Words already written are not undone.
- Write latency: im_we is asserted in the cycle after the low byte is accepted. im_addr and im_wdata are registered and valid in that same cycle.
- Back-to-back bytes: the minimum frame time is 3 + 3N + 1 cycles, because WRITE inserts one stall cycle (rx_ready = 0) per word.
- load_done and the cpu_hold fall occur in the cycle after the CSUM byte is accepted.
- A header byte arriving in the same cycle as a timeout expiry outside IDLE is not accepted as a header. The frame errors and the FSM goes to IDLE first.

## Structure
- Shared package contains: the state enumeration, HDR_BYTE = 8'hA5, and the checksum-width constant.
- One sub-module, loader_timer: a TIMEOUT-bounded counter with clear/enable inputs and an expired output.
- Everything else lives in imem_loader.

## Test plan
- Frame A5 00 02 12 34 AB CD csum=00^02^12^34^AB^CD=0x42 → writes 0x1234 at 0x0000 and 0xABCD at 0x0001, load_done pulses once, cpu_hold falls, load_err = 0.
- Same frame with csum 0x43 → both words written, load_err = 1, cpu_hold stays 1, no load_done.
- Count 00 00 → load_err = 1 right after CNT_LO, no im_we, FSM back in IDLE. A following valid frame clears load_err and loads.
- Leading bytes FF 00 3C before A5 → ignored, and the following frame loads normally.
- Stop mid-frame after the high byte, with TIMEOUT = 16 → load_err set after 16 idle cycles, no write for the incomplete word, and the next frame is accepted.
- Assert reset_n (high) during DATA_LO → all outputs return to their reset values asynchronously, and a subsequent complete frame loads correctly starting at BASE_ADDR.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader: FSM states,
// frame header value and checksum helpers.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_WRITE,
        ST_CSUM
    } loader_state_t;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam int         CSUM_W   = 8;
    localparam int         IDX_W    = 17;

    function automatic logic [CSUM_W-1:0] csumStep(
        input logic [CSUM_W-1:0] acc,
        input logic [7:0]        data
    );
        return acc ^ data;
    endfunction

endpackage

// File: rtl/imem_loader_timer.sv
// Inter-byte idle counter for the loader; saturates at TIMEOUT and flags expiry
// until it is cleared.
module loader_timer #(
    parameter int TIMEOUT = 65535
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int               CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/imem_loader.sv
// Frame parser that streams big-endian 16-bit words into instruction memory and
// holds the CPU in reset until a frame with a good checksum has been loaded.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [15:0]       im_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [32:0] DEPTH = 33'(1) << ADDR_W;

    loader_state_t     r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [15:0]       r_count;
    logic [CSUM_W-1:0] r_csum;
    logic [7:0]        r_hi;
    logic              r_imWe;
    logic [ADDR_W-1:0] r_imAddr;
    logic [15:0]       r_imWdata;
    logic              r_cpuHold;
    logic              r_loadDone;
    logic              r_loadErr;

    logic              w_accept;
    logic              w_timerEn;
    logic              w_timerClr;
    logic              w_expired;
    logic [15:0]       w_nFull;
    logic              w_nBad;
    logic [IDX_W-1:0]  w_idxNext;

    assign rx_ready   = (r_state != ST_WRITE);
    assign w_accept   = rx_valid && rx_ready;
    assign w_timerEn  = (r_state != ST_IDLE) && (r_state != ST_WRITE);
    assign w_timerClr = w_accept || (r_state == ST_IDLE);

    // N is only meaningful while in CNT_LO, where rx_data carries the low count byte.
    assign w_nFull    = {r_count[15:8], rx_data};
    assign w_nBad     = (w_nFull == 16'd0) || ({17'd0, w_nFull} > DEPTH);
    assign w_idxNext  = r_idx + IDX_W'(1);

    loader_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk     (clk),
        .i_rst     (reset_n),
        .i_clear   (w_timerClr),
        .i_enable  (w_timerEn),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_count    <= '0;
            r_csum     <= '0;
            r_hi       <= '0;
            r_imWe     <= 1'b0;
            r_imAddr   <= BASE_ADDR;
            r_imWdata  <= '0;
            r_cpuHold  <= 1'b1;
            r_loadDone <= 1'b0;
            r_loadErr  <= 1'b0;
        end else begin
            r_loadDone <= 1'b0;
            // An expiry outranks any byte arriving in the same cycle, headers included.
            if (w_timerEn && w_expired) begin
                r_loadErr <= 1'b1;
                r_state   <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept && (rx_data == HDR_BYTE)) begin
                            r_loadErr <= 1'b0;
                            r_idx     <= '0;
                            r_csum    <= '0;
                            r_cpuHold <= 1'b1;
                            r_state   <= ST_CNT_HI;
                        end
                    end
                    ST_CNT_HI: begin
                        if (w_accept) begin
                            r_count[15:8] <= rx_data;
                            r_csum        <= csumStep(r_csum, rx_data);
                            r_state       <= ST_CNT_LO;
                        end
                    end
                    ST_CNT_LO: begin
                        if (w_accept) begin
                            r_count <= w_nFull;
                            r_csum  <= csumStep(r_csum, rx_data);
                            if (w_nBad) begin
                                r_loadErr <= 1'b1;
                                r_state   <= ST_IDLE;
                            end else begin
                                r_state <= ST_DATA_HI;
                            end
                        end
                    end
                    ST_DATA_HI: begin
                        if (w_accept) begin
                            r_hi    <= rx_data;
                            r_csum  <= csumStep(r_csum, rx_data);
                            r_state <= ST_DATA_LO;
                        end
                    end
                    ST_DATA_LO: begin
                        if (w_accept) begin
                            r_csum    <= csumStep(r_csum, rx_data);
                            r_imWe    <= 1'b1;
                            r_imAddr  <= BASE_ADDR + ADDR_W'(r_idx);
                            r_imWdata <= {r_hi, rx_data};
                            r_state   <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        r_imWe <= 1'b0;
                        r_idx  <= w_idxNext;
                        if (w_idxNext == {1'b0, r_count}) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_state <= ST_DATA_HI;
                        end
                    end
                    ST_CSUM: begin
                        if (w_accept) begin
                            if (rx_data == r_csum) begin
                                r_loadDone <= 1'b1;
                                r_cpuHold  <= 1'b0;
                            end else begin
                                r_loadErr <= 1'b1;
                            end
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign im_we     = r_imWe;
    assign im_addr   = r_imAddr;
    assign im_wdata  = r_imWdata;
    assign cpu_hold  = r_cpuHold;
    assign load_done = r_loadDone;
    assign load_err  = r_loadErr;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized frames against a frame-level reference model; a
// negedge monitor logs memory writes, done pulses and write latency.
module tb_imem_loader;

    localparam int          ADDR_W  = 16;
    localparam logic [15:0] BASE    = 16'h0000;
    localparam int          TMO     = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        im_we;
    logic [15:0] im_addr;
    logic [15:0] im_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    int total = 0;
    int bad   = 0;

    logic [15:0] wrAddrQ[$];
    logic [15:0] wrDataQ[$];
    logic [15:0] txWords[$];
    int          doneCount  = 0;
    int          latErr     = 0;
    int          readyErr   = 0;
    int          negCycle   = 0;
    int          lastAccept = -10;

    imem_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE),
        .TIMEOUT   (TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    // Writes must land exactly one cycle after the accepted low byte, with rx_ready low.
    always @(negedge clk) begin
        negCycle++;
        if (im_we) begin
            wrAddrQ.push_back(im_addr);
            wrDataQ.push_back(im_wdata);
            if (lastAccept != negCycle - 1) latErr++;
            if (rx_ready) readyErr++;
        end
        if (load_done) doneCount++;
        if (rx_valid && rx_ready) lastAccept = negCycle;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int waitCnt;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        rx_valid = 1'b1;
        rx_data  = b;
        waitCnt  = 0;
        @(negedge clk);
        while (!rx_ready && waitCnt < 8) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("rxReadyWait", 32'(waitCnt < 8), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic clearLog();
        wrAddrQ.delete();
        wrDataQ.delete();
        doneCount = 0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rxReady"},  32'(rx_ready),  32'd1);
        checkOutput({tag, "_imWe"},     32'(im_we),     32'd0);
        checkOutput({tag, "_imAddr"},   32'(im_addr),   32'(BASE));
        checkOutput({tag, "_imWdata"},  32'(im_wdata),  32'd0);
        checkOutput({tag, "_cpuHold"},  32'(cpu_hold),  32'd1);
        checkOutput({tag, "_loadDone"}, 32'(load_done), 32'd0);
        checkOutput({tag, "_loadErr"},  32'(load_err),  32'd0);
    endtask

    // Reference model: a frame of txWords is a list of writes at BASE+i, and the
    // outcome depends only on whether the transmitted checksum was the true XOR.
    task automatic runFrame(input bit corrupt, input int junk, input int maxGap);
        logic [7:0] cs;
        logic [7:0] b;
        int         n;
        n = txWords.size();
        clearLog();
        for (int j = 0; j < junk; j++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            applyStimulus(b, $urandom_range(0, maxGap));
        end
        applyStimulus(8'hA5, $urandom_range(0, maxGap));
        cs = 8'(n >> 8) ^ 8'(n);
        applyStimulus(8'(n >> 8), $urandom_range(0, maxGap));
        applyStimulus(8'(n), $urandom_range(0, maxGap));
        foreach (txWords[i]) begin
            cs = cs ^ txWords[i][15:8] ^ txWords[i][7:0];
            applyStimulus(txWords[i][15:8], $urandom_range(0, maxGap));
            applyStimulus(txWords[i][7:0], $urandom_range(0, maxGap));
        end
        if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
        applyStimulus(cs, $urandom_range(0, maxGap));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("frameWrites", 32'(wrAddrQ.size()), 32'(n));
        for (int i = 0; i < n && i < wrAddrQ.size(); i++) begin
            checkOutput("frameAddr", 32'(wrAddrQ[i]), 32'(16'(BASE + 16'(i))));
            checkOutput("frameData", 32'(wrDataQ[i]), 32'(txWords[i]));
        end
        checkOutput("frameDone",  32'(doneCount), corrupt ? 32'd0 : 32'd1);
        checkOutput("frameErr",   32'(load_err),  corrupt ? 32'd1 : 32'd0);
        checkOutput("frameHold",  32'(cpu_hold),  corrupt ? 32'd1 : 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] frameA[8];
        reset_n  = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        reset_n = 1'b0;
        @(posedge clk);
        #1;

        // Known-good two-word frame with checksum 0x42.
        frameA = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        clearLog();
        for (int i = 0; i < 8; i++) applyStimulus(frameA[i], 0);
        checkOutput("goodDonePulse", 32'(load_done), 32'd1);
        checkOutput("goodHoldFall",  32'(cpu_hold),  32'd0);
        @(posedge clk);
        #1;
        checkOutput("goodDoneOnce",  32'(load_done), 32'd0);
        checkOutput("goodWrites",    32'(wrAddrQ.size()), 32'd2);
        if (wrAddrQ.size() == 2) begin
            checkOutput("goodAddr0", 32'(wrAddrQ[0]), 32'h0000);
            checkOutput("goodData0", 32'(wrDataQ[0]), 32'h1234);
            checkOutput("goodAddr1", 32'(wrAddrQ[1]), 32'h0001);
            checkOutput("goodData1", 32'(wrDataQ[1]), 32'hABCD);
        end
        checkOutput("goodDoneCount", 32'(doneCount), 32'd1);
        checkOutput("goodErr",       32'(load_err),  32'd0);

        // Same frame with a wrong checksum.
        frameA[7] = 8'h43;
        clearLog();
        for (int i = 0; i < 8; i++) applyStimulus(frameA[i], 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("badWrites", 32'(wrAddrQ.size()), 32'd2);
        checkOutput("badErr",    32'(load_err),  32'd1);
        checkOutput("badHold",   32'(cpu_hold),  32'd1);
        checkOutput("badDone",   32'(doneCount), 32'd0);

        // Zero count aborts straight after CNT_LO.
        clearLog();
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        checkOutput("zeroCntErr", 32'(load_err), 32'd1);
        applyStimulus(8'h12, 2);
        checkOutput("zeroCntIdle", 32'(load_err), 32'd1);
        checkOutput("zeroCntNoWe", 32'(wrAddrQ.size()), 32'd0);
        txWords = '{16'h0BEE, 16'hF00D};
        runFrame(1'b0, 0, 0);

        // Leading junk in IDLE is discarded.
        applyStimulus(8'hFF, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h3C, 0);
        txWords = '{16'h5566, 16'h7788, 16'h99AA};
        runFrame(1'b0, 0, 1);

        // Stall after a high byte: error exactly after TMO idle cycles.
        clearLog();
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h12, 0);
        repeat (TMO) @(posedge clk);
        #1;
        checkOutput("tmoNotYet", 32'(load_err), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("tmoErr",     32'(load_err), 32'd1);
        checkOutput("tmoNoWrite", 32'(wrAddrQ.size()), 32'd0);
        checkOutput("tmoHold",    32'(cpu_hold), 32'd1);
        txWords = '{16'hC0DE};
        runFrame(1'b0, 0, 0);

        // Asynchronous reset while sitting in DATA_LO.
        clearLog();
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        applyStimulus(8'h33, 0);
        checkOutput("preRstWrites", 32'(wrAddrQ.size()), 32'd1);
        #2;
        reset_n = 1'b1;
        #1;
        checkResetValues("midRst");
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        txWords = '{16'h1357, 16'h2468, 16'hACE0};
        runFrame(1'b0, 0, 0);

        // Randomized frames: random length, payload, junk, gaps and corruption.
        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(1, 6);
            txWords.delete();
            for (int w = 0; w < n; w++) txWords.push_back(16'($urandom_range(0, 65535)));
            runFrame($urandom_range(0, 2) == 0, $urandom_range(0, 3), 4);
        end

        checkOutput("writeLatency", 32'(latErr),   32'd0);
        checkOutput("writeStall",   32'(readyErr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
